// File: rtl/ritc_phase_scanner_param.sv
// Phase scanner: selects one asynchronous input bit, synchronises it, and
// counts either high cycles or transitions of that bit over a fixed window
// of 2^CNT_BITS cycles. The result is presented with a level done flag.
//
// Control strobes (select_wr_i, scan_i, abort_i) are single-cycle requests
// sampled on the rising edge. There is no back-pressure. A request that
// arrives when the block cannot act on it is dropped, not queued:
// select_wr_i and scan_i act only in IDLE, and abort_i acts only in SETTLE
// or COUNT. In IDLE, abort_i overrides scan_i. busy_o is high for exactly
// the SETTLE and COUNT cycles. done_o rises after the DONE cycle and stays
// high until the next accepted scan or reset.
module ritc_phase_scanner_param #(
  parameter int NCH         = 3,
  parameter int NBITS       = 12,
  parameter int CNT_BITS    = 7,
  // Synchroniser depth, 2..4 flops behind the registered input mux.
  parameter int SYNC_STAGES = 2,
  localparam int NIN        = NCH * NBITS,
  localparam int SEL_W      = $clog2(NIN)
) (
  input  logic                user_clk_i,
  input  logic                rst_i,
  input  logic [NIN-1:0]      data_i,
  input  logic [SEL_W-1:0]    select_i,
  input  logic                select_wr_i,
  input  logic                mode_i,
  input  logic                scan_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_BITS:0]   scaler_o,
  output logic                first_o,
  output logic                sel_err_o,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // SETTLE runs SYNC_STAGES+1 cycles. That is long enough for a freshly
  // loaded sel_q to pass through the mux flop and the whole synchroniser.
  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SYNC_STAGES);
  localparam logic [SET_W-1:0]    SET_ONE  = SET_W'(1);
  localparam logic [CNT_BITS-1:0] WIN_LAST = '1;
  localparam logic [CNT_BITS-1:0] WIN_ONE  = CNT_BITS'(1);
  localparam logic [SEL_W:0]      NIN_V    = (SEL_W + 1)'(NIN);

  state_t                 state_q;
  state_t                 state_d;

  logic [SEL_W-1:0]       sel_q;
  logic                   mode_q;
  logic                   mux_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev;
  logic                   first_cap;
  logic [SET_W-1:0]       settle_cnt;
  logic [CNT_BITS-1:0]    win_cnt;
  logic [CNT_BITS:0]      hit_cnt;
  logic [CNT_BITS:0]      hit_next;

  logic                   scan_acc;
  logic                   settle_end;
  logic                   count_end;
  logic                   count_fin;
  logic                   sel_ok;
  logic                   inc;

  // The last synchroniser flop is the sample that the counting logic uses.
  assign s = sync_q[SYNC_STAGES-1];

  // A scan starts only from IDLE, and a same-cycle abort cancels it.
  assign scan_acc   = (state_q == IDLE) && scan_i && !abort_i;
  assign settle_end = (state_q == SETTLE) && (settle_cnt == SET_LAST);
  assign count_end  = (state_q == COUNT) && (win_cnt == WIN_LAST);
  // An abort in the final COUNT cycle still cancels the result.
  assign count_fin  = count_end && !abort_i;
  assign sel_ok     = ({1'b0, select_i} < NIN_V);

  // Level mode counts high samples; transition mode counts changes.
  assign inc      = mode_q ? (s ^ s_prev) : s;
  assign hit_next = hit_cnt + {{CNT_BITS{1'b0}}, inc};

  assign busy_o    = (state_q == SETTLE) || (state_q == COUNT);
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge user_clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: scan request, settle and window timing, abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (scan_acc) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (settle_end) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (count_end) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Input path: registered mux of the selected bit, then the synchroniser.
  always_ff @(posedge user_clk_i) begin
    if (rst_i) begin
      mux_q  <= 1'b0;
      sync_q <= '0;
    end else begin
      mux_q  <= data_i[sel_q];
      sync_q <= {sync_q[SYNC_STAGES-2:0], mux_q};
    end
  end

  // Select register and sticky range-error flag. These update only in IDLE.
  always_ff @(posedge user_clk_i) begin
    if (rst_i) begin
      sel_q     <= '0;
      sel_err_o <= 1'b0;
    end else if ((state_q == IDLE) && select_wr_i) begin
      if (sel_ok) begin
        sel_q     <= select_i;
        sel_err_o <= 1'b0;
      end else begin
        sel_err_o <= 1'b1;
      end
    end
  end

  // Scan datapath: settle/window counters, hit counter, result registers.
  always_ff @(posedge user_clk_i) begin
    if (rst_i) begin
      mode_q     <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      hit_cnt    <= '0;
      s_prev     <= 1'b0;
      first_cap  <= 1'b0;
      scaler_o   <= '0;
      first_o    <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      if (scan_acc) begin
        mode_q     <= mode_i;
        done_o     <= 1'b0;
        settle_cnt <= '0;
        win_cnt    <= '0;
        hit_cnt    <= '0;
      end

      if (state_q == SETTLE) begin
        settle_cnt <= settle_cnt + SET_ONE;
        if (settle_end) begin
          s_prev <= s;
        end
      end

      if (state_q == COUNT) begin
        win_cnt <= win_cnt + WIN_ONE;
        hit_cnt <= hit_next;
        s_prev  <= s;
        if (win_cnt == '0) begin
          first_cap <= s;
        end
        // Results are published only when a window completes. An abort
        // therefore leaves the previous result visible.
        if (count_fin) begin
          scaler_o <= hit_next;
          first_o  <= first_cap;
        end
      end

      if (state_q == DONE) begin
        done_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ritc_phase_scanner_param.sv
// Bench for ritc_phase_scanner_param at the default parameters.
module tb_ritc_phase_scanner_param;

  localparam int NCH         = 3;
  localparam int NBITS       = 12;
  localparam int CNT_BITS    = 7;
  localparam int SYNC_STAGES = 2;
  localparam int NIN         = NCH * NBITS;
  localparam int SEL_W       = $clog2(NIN);
  localparam int WIN         = 1 << CNT_BITS;
  localparam int LAT         = SYNC_STAGES + WIN + 3;
  localparam int EW          = CNT_BITS + 3;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic [NIN-1:0]      data_i;
  logic [NIN-1:0]      data_base = '0;
  logic                tog_en = 1'b0;
  logic [1:0]          tog_cnt = 2'd0;
  logic [SEL_W-1:0]    select_i = '0;
  logic                select_wr_i = 1'b0;
  logic                mode_i = 1'b0;
  logic                scan_i = 1'b0;
  logic                abort_i = 1'b0;
  logic                busy_o;
  logic                done_o;
  logic [CNT_BITS:0]   scaler_o;
  logic                first_o;
  logic                sel_err_o;
  logic [1:0]          state_dbg;

  // Each entry is {check_first, first, scaler}.
  logic [EW-1:0]       exp_q[$];
  int                  n_checks = 0;
  int                  n_errors = 0;

  ritc_phase_scanner_param #(
    .NCH(NCH), .NBITS(NBITS), .CNT_BITS(CNT_BITS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .user_clk_i  (clk),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .select_i    (select_i),
    .select_wr_i (select_wr_i),
    .mode_i      (mode_i),
    .scan_i      (scan_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .scaler_o    (scaler_o),
    .first_o     (first_o),
    .sel_err_o   (sel_err_o),
    .state_dbg   (state_dbg)
  );

  // Clock and a free-running 2-high/2-low pattern for bit 17.
  always #5 clk = ~clk;
  always @(negedge clk) tog_cnt <= tog_cnt + 2'd1;
  assign data_i = data_base | (tog_en ? ({{(NIN-1){1'b0}}, tog_cnt[1]} << 17) : '0);

  task automatic do_reset;
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic write_sel(input logic [SEL_W-1:0] v);
    @(negedge clk);
    select_i    = v;
    select_wr_i = 1'b1;
    @(negedge clk);
    select_wr_i = 1'b0;
  endtask

  // Push the expectation, issue a scan, then wait for done_o within a bound.
  // If disturb is set, the task also pulses scan_i and select_wr_i mid-scan.
  task automatic run_scan(input logic m, input logic [CNT_BITS:0] es,
                          input logic ef, input logic cf, input logic disturb);
    logic [EW-1:0] e;
    logic          got;
    int            lat;
    exp_q.push_back({cf, ef, es});
    @(negedge clk);
    mode_i = m;
    scan_i = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk);
      scan_i      = 1'b0;
      select_wr_i = 1'b0;
      if (k == 1) begin
        n_checks++;
        if (busy_o !== 1'b1) begin
          n_errors++;
          $display("FAIL scan_busy_start: got %b expected 1", busy_o);
        end
        n_checks++;
        if (done_o !== 1'b0) begin
          n_errors++;
          $display("FAIL scan_done_clear: got %b expected 0", done_o);
        end
      end
      if (done_o === 1'b1) begin
        got = 1'b1;
        lat = k;
        break;
      end
      if (disturb && (k == 10 || k == 60 || k == LAT - 3)) begin
        scan_i      = 1'b1;
        select_wr_i = 1'b1;
        select_i    = 3;
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL scan_timeout: got no done_o expected done within %0d cycles", LAT + 20);
    end else begin
      n_checks++;
      if (lat != LAT) begin
        n_errors++;
        $display("FAIL scan_latency: got %0d expected %0d", lat, LAT);
      end
      n_checks++;
      if (busy_o !== 1'b0) begin
        n_errors++;
        $display("FAIL scan_busy_end: got %b expected 0", busy_o);
      end
      n_checks++;
      if (scaler_o !== e[CNT_BITS:0]) begin
        n_errors++;
        $display("FAIL scan_scaler: got %0d expected %0d", scaler_o, e[CNT_BITS:0]);
      end
      if (e[EW-1]) begin
        n_checks++;
        if (first_o !== e[EW-2]) begin
          n_errors++;
          $display("FAIL scan_first: got %b expected %b", first_o, e[EW-2]);
        end
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++;
    if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++;
    if (done_o !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
    n_checks++;
    if (scaler_o !== '0) begin n_errors++; $display("FAIL reset_scaler: got %0d expected 0", scaler_o); end
    n_checks++;
    if (first_o !== 1'b0) begin n_errors++; $display("FAIL reset_first: got %b expected 0", first_o); end
    n_checks++;
    if (sel_err_o !== 1'b0) begin n_errors++; $display("FAIL reset_sel_err: got %b expected 0", sel_err_o); end
    n_checks++;
    if (state_dbg !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_level_const;
    data_base    = '0;
    data_base[5] = 1'b1;
    write_sel(5);
    run_scan(1'b0, 8'd128, 1'b1, 1'b1, 1'b0);
    run_scan(1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
    write_sel(3);
    run_scan(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_toggle;
    data_base = '0;
    tog_en    = 1'b1;
    write_sel(17);
    run_scan(1'b0, 8'd64, 1'b0, 1'b0, 1'b0);
    run_scan(1'b1, 8'd64, 1'b0, 1'b0, 1'b0);
    tog_en = 1'b0;
  endtask

  task automatic test_random;
    int idx;
    logic b;
    for (int i = 0; i < 3; i++) begin
      idx       = $urandom_range(0, NIN - 1);
      data_base = {$urandom, $urandom};
      b         = data_base[idx];
      write_sel(SEL_W'(idx));
      run_scan(1'b0, b ? 8'd128 : 8'd0, b, 1'b1, 1'b0);
      run_scan(1'b1, 8'd0, b, 1'b1, 1'b0);
    end
  endtask

  task automatic test_sel_err;
    data_base    = '0;
    data_base[5] = 1'b1;
    write_sel(5);
    write_sel(36);
    n_checks++;
    if (sel_err_o !== 1'b1) begin n_errors++; $display("FAIL sel_err_set: got %b expected 1", sel_err_o); end
    run_scan(1'b0, 8'd128, 1'b1, 1'b1, 1'b0);
    write_sel(0);
    n_checks++;
    if (sel_err_o !== 1'b0) begin n_errors++; $display("FAIL sel_err_clear: got %b expected 0", sel_err_o); end
    run_scan(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    write_sel(SEL_W'($urandom_range(NIN, (1 << SEL_W) - 1)));
    n_checks++;
    if (sel_err_o !== 1'b1) begin n_errors++; $display("FAIL sel_err_rand: got %b expected 1", sel_err_o); end
  endtask

  task automatic test_abort;
    data_base    = '0;
    data_base[5] = 1'b1;
    write_sel(5);
    run_scan(1'b0, 8'd128, 1'b1, 1'b1, 1'b0);
    write_sel(3);
    @(negedge clk);
    mode_i = 1'b0;
    scan_i = 1'b1;
    for (int k = 1; k <= 54; k++) begin
      @(negedge clk);
      scan_i = 1'b0;
    end
    n_checks++;
    if (busy_o !== 1'b1) begin n_errors++; $display("FAIL abort_pre_busy: got %b expected 1", busy_o); end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b expected 0", busy_o); end
    n_checks++;
    if (done_o !== 1'b0) begin n_errors++; $display("FAIL abort_done: got %b expected 0", done_o); end
    n_checks++;
    if (scaler_o !== 8'd128) begin n_errors++; $display("FAIL abort_scaler: got %0d expected 128", scaler_o); end
    n_checks++;
    if (first_o !== 1'b1) begin n_errors++; $display("FAIL abort_first: got %b expected 1", first_o); end
    repeat (LAT) @(negedge clk);
    n_checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_stays_idle: got done=%b busy=%b expected done=0 busy=0", done_o, busy_o);
    end
  endtask

  task automatic test_reset_mid;
    write_sel(40);
    n_checks++;
    if (sel_err_o !== 1'b1) begin n_errors++; $display("FAIL rstmid_pre_err: got %b expected 1", sel_err_o); end
    @(negedge clk);
    mode_i = 1'b1;
    scan_i = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      scan_i = 1'b0;
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    n_checks++;
    if ({busy_o, done_o, first_o, sel_err_o} !== 4'b0000 || scaler_o !== '0 || state_dbg !== 2'd0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: got busy=%b done=%b first=%b err=%b scaler=%0d state=%0d expected all 0",
               busy_o, done_o, first_o, sel_err_o, scaler_o, state_dbg);
    end
    data_base = '0;
    data_base[0] = 1'b1;
    run_scan(1'b0, 8'd128, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_busy_ignore;
    data_base    = '0;
    data_base[5] = 1'b1;
    write_sel(5);
    run_scan(1'b0, 8'd128, 1'b1, 1'b1, 1'b1);
    run_scan(1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_abort_scan_same;
    @(negedge clk);
    scan_i  = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    scan_i  = 1'b0;
    abort_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) begin n_errors++; $display("FAIL same_busy: got %b expected 0", busy_o); end
    n_checks++;
    if (done_o !== 1'b1) begin n_errors++; $display("FAIL same_done: got %b expected 1", done_o); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b1 || state_dbg !== 2'd0) begin
      n_errors++;
      $display("FAIL same_later: got busy=%b done=%b state=%0d expected busy=0 done=1 state=0",
               busy_o, done_o, state_dbg);
    end
  endtask

  task automatic test_back_to_back;
    int idx;
    logic b;
    idx       = $urandom_range(0, NIN - 1);
    data_base = {$urandom, $urandom};
    b         = data_base[idx];
    write_sel(SEL_W'(idx));
    run_scan(1'b0, b ? 8'd128 : 8'd0, b, 1'b1, 1'b0);
    run_scan(1'b0, b ? 8'd128 : 8'd0, b, 1'b1, 1'b0);
    run_scan(1'b1, 8'd0, b, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_level_const();
    test_toggle();
    test_random();
    test_sel_err();
    test_abort();
    test_reset_mid();
    test_busy_ignore();
    test_abort_scan_same();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ritc_phase_scanner_param.md
RITC_PHASE_SCANNER_PARAM -- requirements
Module: ritc_phase_scanner_param

Interface
REQ-001 Parameter NCH, default 3, number of input channels.
REQ-002 Parameter NBITS, default 12, bits per channel.
REQ-003 Parameter CNT_BITS, default 7, scan window = 2^CNT_BITS cycles.
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser depth (legal range 2..4).
REQ-005 Derived: NIN = NCH*NBITS; SEL_W = clog2(NIN).
REQ-006 user_clk_i  in  1  sole clock; all logic on rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 data_i  in  NIN  asynchronous sampled inputs; bit c*NBITS+b is channel c, bit b.
REQ-009 select_i  in  SEL_W  input index to scan.
REQ-010 select_wr_i  in  1  one-cycle strobe that loads select_i.
REQ-011 mode_i  in  1  0 = level count, 1 = transition count; sampled on scan accept.
REQ-012 scan_i  in  1  one-cycle scan request.
REQ-013 abort_i  in  1  one-cycle abort.
REQ-014 busy_o  out  1  high while a scan is in progress.
REQ-015 done_o  out  1  level; result valid.
REQ-016 scaler_o  out  CNT_BITS+1  scan result.
REQ-017 first_o  out  1  synchronised sample value at the first COUNT cycle.
REQ-018 sel_err_o  out  1  sticky out-of-range select flag.

Function
REQ-019 The path SHALL be: registered mux data_i[sel_q], then SYNC_STAGES flops; the last flop output is sample s.
REQ-020 select_wr_i in IDLE with select_i < NIN SHALL load sel_q and clear sel_err_o; select_i >= NIN SHALL leave sel_q unchanged and set sel_err_o.
REQ-021 select_wr_i while busy_o=1 SHALL be ignored (no sel_q change, no sel_err_o change).
REQ-022 FSM states SHALL be IDLE, SETTLE, COUNT, DONE.
REQ-023 IDLE: scan_i=1 and abort_i=0 -> SETTLE; latch mode_i; clear done_o; busy_o=1 from the next cycle.
REQ-024 SETTLE SHALL last exactly SYNC_STAGES+1 cycles, then go to COUNT; the s value in its last cycle is stored as s_prev.
REQ-025 COUNT SHALL last exactly 2^CNT_BITS cycles; the counter SHALL be CNT_BITS+1 wide and cleared on SETTLE entry.
REQ-026 Level mode: the counter SHALL increment on each COUNT cycle where s=1.
REQ-027 Transition mode: the counter SHALL increment on each COUNT cycle where s != s_prev; s_prev updates every COUNT cycle.
REQ-028 first_o SHALL load s on the first COUNT cycle.
REQ-029 COUNT -> DONE SHALL load scaler_o with the final count; the maximum value is 2^CNT_BITS, so no wrap is possible.
REQ-030 DONE SHALL last one cycle, then go to IDLE.
REQ-031 In DONE, busy_o SHALL drop and done_o SHALL rise.
REQ-032 done_o SHALL stay high until the next accepted scan_i or rst_i.
REQ-033 With scan_i sampled at cycle T, done_o SHALL first be high at T+SYNC_STAGES+2^CNT_BITS+3.
REQ-034 scan_i while busy_o=1 SHALL be ignored.
REQ-035 abort_i in SETTLE or COUNT SHALL go to IDLE next cycle with busy_o=0.
REQ-036 On abort, done_o SHALL stay 0, and scaler_o and first_o SHALL hold their prior values.
REQ-037 abort_i and scan_i in the same IDLE cycle: abort_i SHALL win and no scan starts.

Reset
REQ-038 rst_i SHALL, from any state including mid-scan, force IDLE next cycle.
REQ-039 rst_i SHALL set busy_o=0, done_o=0, scaler_o=0, first_o=0, sel_err_o=0, sel_q=0, mode=0, and clear the counter and synchroniser flops.

Verification (NCH=3, NBITS=12, CNT_BITS=7, SYNC_STAGES=2)
REQ-040 Select 5, data_i[5]=1 constant, level scan at T -> done_o high at T+133, scaler_o=128, first_o=1.
REQ-041 data_i[17] toggles with 2-high/2-low period, select 17 -> level scaler_o=64; transition scaler_o=64.
REQ-042 select_wr_i with select_i=36 -> sel_err_o=1, sel_q unchanged; then select_i=0 written -> sel_err_o=0.
REQ-043 Abort at COUNT cycle 50 -> busy_o=0 next cycle, done_o=0, scaler_o keeps prior value; rst_i mid-COUNT -> all outputs 0.
REQ-044 scan_i and select_wr_i pulsed while busy -> ignored; result equals the uninterrupted scan, sel_q unchanged.
REQ-045 scan_i with abort_i in the same IDLE cycle -> busy_o stays 0 and done_o is unchanged.
